// File: rtl/vr74x74.sv
// 74x74-style positive-edge D flip-flop bank.
// Each bit has an active-low preset and clear; RST clears the whole bank.
module vr74x74 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] PR_L,
    input  logic [WIDTH-1:0] CLR_L,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic pr_n;
        logic clr_n;
        logic d_d;
        logic s_q;

        assign pr_n  = PR_L[i];
        assign clr_n = CLR_L[i];
        assign d_d   = D[i];

        always_ff @(posedge CLK or posedge RST or negedge pr_n or negedge clr_n) begin
            if (RST) begin
                s_q <= 1'b0;
            end else if (!pr_n) begin
                s_q <= 1'b1;
            end else if (!clr_n) begin
                s_q <= 1'b0;
            end else begin
                s_q <= d_d;
            end
        end

        // Held async levels drive the pins directly, so they win even before
        // the stored bit has caught up (e.g. RST released while PR_L is low).
        assign Q[i]  = RST    ? 1'b0 :
                       !pr_n  ? 1'b1 :
                       !clr_n ? 1'b0 :
                                s_q;

        assign QN[i] = RST    ? 1'b1 :
                       !pr_n  ? !clr_n :
                       !clr_n ? 1'b1 :
                                !s_q;
    end

endmodule

// File: tb/tb_vr74x74.sv
// Directed bench for vr74x74: single 74x74 section plus a 4-bit bank.
`timescale 1ns/1ps
module tb_vr74x74;

    logic       clk;
    logic       rst1, d1, pr1, clr1, q1, qn1;
    logic       rst4;
    logic [3:0] d4, pr4, clr4, q4, qn4;

    int n_chk;
    int n_err;

    vr74x74 #(.WIDTH(1)) u_one (
        .CLK(clk), .RST(rst1), .D(d1), .PR_L(pr1), .CLR_L(clr1),
        .Q(q1), .QN(qn1)
    );

    vr74x74 #(.WIDTH(4)) u_four (
        .CLK(clk), .RST(rst4), .D(d4), .PR_L(pr4), .CLR_L(clr4),
        .Q(q4), .QN(qn4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic at(input int t);
        #(t - $time);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst1 = 1'b1; d1 = 1'b0; pr1 = 1'b1; clr1 = 1'b1;
        rst4 = 1'b1; d4 = 4'h0; pr4 = 4'hF; clr4 = 4'hF;

        at(1);   check("reset", {6'b0, q1, qn1}, 8'b01);
        check("reset4", {q4, qn4}, 8'h0F);
        at(2);   rst1 = 1'b0; rst4 = 1'b0;
        at(3);   check("after_rst", {6'b0, q1, qn1}, 8'b01);

        at(10);  pr1 = 1'b0;
        at(11);  check("preset_async", {6'b0, q1, qn1}, 8'b10);
        at(16);  check("preset_over_edge", {6'b0, q1, qn1}, 8'b10);
        at(20);  pr1 = 1'b1;
        at(21);  check("preset_release", {6'b0, q1, qn1}, 8'b10);
        at(26);  check("edge25_d0", {6'b0, q1, qn1}, 8'b01);

        at(30);  clr1 = 1'b0;
        at(31);  check("clear_async", {6'b0, q1, qn1}, 8'b01);
        at(36);  check("clear_over_edge", {6'b0, q1, qn1}, 8'b01);
        at(40);  clr1 = 1'b1;

        at(50);  d1 = 1'b1;
        at(52);  check("d_between_edges", {6'b0, q1, qn1}, 8'b01);
        at(56);  check("edge55_d1", {6'b0, q1, qn1}, 8'b10);
        at(60);  d1 = 1'b0;
        at(66);  check("edge65_d0", {6'b0, q1, qn1}, 8'b01);

        at(70);  pr1 = 1'b0; clr1 = 1'b0;
        at(71);  check("both_low", {6'b0, q1, qn1}, 8'b11);
        at(76);  check("both_low_edge", {6'b0, q1, qn1}, 8'b11);
        at(80);  pr1 = 1'b1; clr1 = 1'b1;
        at(81);  check("both_release", {6'b0, q1, qn1}, 8'b10);
        at(86);  check("edge85_after_both", {6'b0, q1, qn1}, 8'b01);

        at(90);  d1 = 1'b1; pr1 = 1'b0; rst1 = 1'b1;
        at(91);  check("rst_over_preset", {6'b0, q1, qn1}, 8'b01);
        at(96);  check("rst_edge95", {6'b0, q1, qn1}, 8'b01);
        at(106); check("rst_edge105", {6'b0, q1, qn1}, 8'b01);
        at(110); rst1 = 1'b0;
        at(111); check("rst_rel_preset_held", {6'b0, q1, qn1}, 8'b10);
        at(118); pr1 = 1'b1;
        at(119); check("preset_rel_hold", {6'b0, q1, qn1}, 8'b10);
        at(120); d1 = 1'b0;
        at(126); check("edge125_d0", {6'b0, q1, qn1}, 8'b01);

        at(130); d4 = 4'hF;
        at(136); check("bank_load_f", {q4, qn4}, 8'hF0);
        at(140); d4 = 4'b1010; clr4 = 4'b1101;
        at(141); check("bank_clr_bit1", {q4, qn4}, 8'b1101_0010);
        at(142); clr4 = 4'hF;
        at(143); check("bank_clr_release", {q4, qn4}, 8'b1101_0010);
        at(146); check("bank_edge_1010", {q4, qn4}, 8'b1010_0101);
        at(150); pr4 = 4'b1110;
        at(151); check("bank_pr_bit0", {q4, qn4}, 8'b1011_0100);
        at(152); pr4 = 4'hF;
        at(156); check("bank_edge_again", {q4, qn4}, 8'b1010_0101);
        at(160); rst4 = 1'b1;
        at(161); check("bank_rst", {q4, qn4}, 8'h0F);
        check("bank_rst_indep", {6'b0, q1, qn1}, 8'b01);

        at(170);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
